// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   - lsu_state_t : transaction FSM states
//   - lsu_req_t   : registered copy of an accepted request
//   - F3_*        : RV32I load/store funct3 encodings
//   - EXC_*       : exception cause codes returned on exc_cause_o
//   - fault_cause / misalign_cause : pick the load or store flavour of a cause
package lsu_pkg;

  localparam logic [31:0] LSU_MEM_BASE  = 32'h0000_0000;
  localparam int          LSU_MEM_WORDS = 2048;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } lsu_req_t;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] EXC_NONE        = 4'd0;
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  function automatic logic [3:0] fault_cause(input logic we);
    return we ? EXC_ST_FAULT : EXC_LD_FAULT;
  endfunction

  function automatic logic [3:0] misalign_cause(input logic we);
    return we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
  endfunction

endpackage

// File: rtl/lsu_check.sv
// lsu_check: combinational legality checker for one load/store request.
//   we     : 1 = store, 0 = load
//   funct3 : RV32I funct3 of the access
//   addr   : effective byte address
//   ok     : 1 when the access may proceed to memory
//   cause  : exception cause when ok = 0, otherwise 0
// Priority: illegal width, then misalignment, then out-of-range.
module lsu_check
  import lsu_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = LSU_MEM_BASE,
  parameter int          MEM_WORDS = LSU_MEM_WORDS
) (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic        ok,
  output logic [3:0]  cause
);

  logic        illegal;
  logic        misalign;
  logic        in_range;
  logic [32:0] addr_ext;
  logic [32:0] lo_ext;
  logic [32:0] hi_ext;

  // One extra bit keeps the upper bound from wrapping near 32'hFFFF_FFFC.
  assign addr_ext = {1'b0, addr};
  assign lo_ext   = {1'b0, MEM_BASE};
  assign hi_ext   = lo_ext + (33'(MEM_WORDS) << 2);

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latch).
    ok       = 1'b1;
    cause    = EXC_NONE;
    illegal  = we ? (funct3 >= 3'd3)
                  : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
    // funct3[1:0] is the size code for both loads and stores (00 byte, 01 half, 10 word).
    misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    in_range = (addr_ext >= lo_ext) && (addr_ext < hi_ext);

    if (illegal) begin
      ok    = 1'b0;
      cause = fault_cause(we);
    end else if (misalign) begin
      ok    = 1'b0;
      cause = misalign_cause(we);
    end else if (!in_range) begin
      ok    = 1'b0;
      cause = fault_cause(we);
    end
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit, initiator side of the data-RAM port.
//   Request (MEM stage)  : req_valid_i/req_ready_o, req_we_i, req_funct3_i,
//                          req_addr_i, req_wdata_i, req_rd_i
//   Response (writeback) : resp_valid_o/resp_ready_i, resp_is_load_o,
//                          resp_data_o, resp_rd_o, exc_o, exc_cause_o, exc_tval_o
//   Control              : flush_i discards the pending response
//   RAM port             : mem_addr_o, mem_data_o, mem_size_o, mem_we_o,
//                          mem_re_o, mem_data_i (valid the cycle after mem_re_o)
// One transaction in flight: IDLE -> ISSUE -> (CAPTURE) -> RESP, or
// IDLE -> RESP directly when the request fails the legality check.
module lsu
  import lsu_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = LSU_MEM_BASE,
  parameter int          MEM_WORDS = LSU_MEM_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_is_load_o,
  output logic [31:0] resp_data_o,
  output logic [4:0]  resp_rd_o,
  output logic        exc_o,
  output logic [3:0]  exc_cause_o,
  output logic [31:0] exc_tval_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  output logic [2:0]  mem_size_o,
  input  logic [31:0] mem_data_i
);

  lsu_state_t  state_q, state_d;
  lsu_req_t    req_q;
  logic        exc_q;
  logic [3:0]  cause_q;
  logic [31:0] tval_q;
  logic        is_load_q;
  logic [31:0] rdata_q;
  // Set when a flush hits ISSUE/CAPTURE: the access completes but no response is sent.
  logic        drop_q;

  logic        chk_ok;
  logic [3:0]  chk_cause;
  logic        accept;

  lsu_check #(
    .MEM_BASE  (MEM_BASE),
    .MEM_WORDS (MEM_WORDS)
  ) u_check (
    .we     (req_we_i),
    .funct3 (req_funct3_i),
    .addr   (req_addr_i),
    .ok     (chk_ok),
    .cause  (chk_cause)
  );

  assign accept = (state_q == ST_IDLE) && req_valid_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next state and FSM-decoded outputs. Only registered state feeds the
  // outputs (plus flush_i on resp_valid_o), so req_valid_i and resp_ready_i
  // never reach an output combinationally.
  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    mem_re_o     = 1'b0;
    mem_we_o     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = chk_ok ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: begin
        mem_re_o = !req_q.we;
        mem_we_o = req_q.we;
        state_d  = req_q.we ? ST_RESP : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_o = !drop_q && !flush_i;
        if (drop_q || flush_i || resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request, response and exception registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      exc_q     <= 1'b0;
      cause_q   <= EXC_NONE;
      tval_q    <= '0;
      is_load_q <= 1'b0;
      rdata_q   <= '0;
      drop_q    <= 1'b0;
    end else begin
      if (accept) begin
        req_q.we     <= req_we_i;
        req_q.funct3 <= req_funct3_i;
        req_q.addr   <= req_addr_i;
        req_q.wdata  <= req_wdata_i;
        req_q.rd     <= req_rd_i;
        exc_q        <= !chk_ok;
        cause_q      <= chk_ok ? EXC_NONE : chk_cause;
        tval_q       <= chk_ok ? 32'h0 : req_addr_i;
        is_load_q    <= chk_ok && !req_we_i;
        rdata_q      <= '0;
        drop_q       <= 1'b0;
      end

      if ((state_q == ST_ISSUE || state_q == ST_CAPTURE) && flush_i) begin
        drop_q <= 1'b1;
      end

      if (state_q == ST_CAPTURE) begin
        rdata_q <= mem_data_i;
      end
    end
  end

  // RAM address/data/size come straight from the request registers and
  // therefore stay put for the whole transaction.
  assign mem_addr_o     = req_q.addr;
  assign mem_data_o     = req_q.wdata;
  assign mem_size_o     = req_q.funct3;

  assign resp_is_load_o = is_load_q;
  assign resp_data_o    = rdata_q;
  assign resp_rd_o      = req_q.rd;
  assign exc_o          = exc_q;
  assign exc_cause_o    = cause_q;
  assign exc_tval_o     = tval_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu. A byte-array RAM model serves the
// RAM port (sign/zero extension done on the RAM side). Directed vectors in a
// table are applied one transaction at a time; stall, flush and mid-
// transaction reset sequences are hand-written.
module tb_lsu;
  import lsu_pkg::*;

  localparam logic [31:0] MB = 32'h0000_0000;
  localparam int          MW = 2048;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        flush_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic        resp_is_load_o;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_rd_o;
  logic        exc_o;
  logic [3:0]  exc_cause_o;
  logic [31:0] exc_tval_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_we_o;
  logic        mem_re_o;
  logic [2:0]  mem_size_o;
  logic [31:0] mem_data_i;

  logic        ref_we;
  logic [2:0]  ref_f3;
  logic [31:0] ref_addr;
  logic        ref_ok;
  logic [3:0]  ref_cause;

  lsu #(.MEM_BASE(MB), .MEM_WORDS(MW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_funct3_i   (req_funct3_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_rd_i       (req_rd_i),
    .flush_i        (flush_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_is_load_o (resp_is_load_o),
    .resp_data_o    (resp_data_o),
    .resp_rd_o      (resp_rd_o),
    .exc_o          (exc_o),
    .exc_cause_o    (exc_cause_o),
    .exc_tval_o     (exc_tval_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_we_o       (mem_we_o),
    .mem_re_o       (mem_re_o),
    .mem_size_o     (mem_size_o),
    .mem_data_i     (mem_data_i)
  );

  lsu_check #(.MEM_BASE(MB), .MEM_WORDS(MW)) ref_chk (
    .we     (ref_we),
    .funct3 (ref_f3),
    .addr   (ref_addr),
    .ok     (ref_ok),
    .cause  (ref_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: little-endian bytes, write on strobe, read data one cycle later.
  logic [7:0] ram [0:MW*4-1];

  function automatic logic [31:0] ram_read(input logic [12:0] a, input logic [2:0] sz);
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] r;
    b0 = ram[a];
    b1 = ram[a + 13'd1];
    b2 = ram[a + 13'd2];
    b3 = ram[a + 13'd3];
    case (sz)
      3'b000:  r = {{24{b0[7]}}, b0};
      3'b001:  r = {{16{b1[7]}}, b1, b0};
      3'b010:  r = {b3, b2, b1, b0};
      3'b100:  r = {24'h0, b0};
      3'b101:  r = {16'h0, b1, b0};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_we_o) begin
      ram[mem_addr_o[12:0]] <= mem_data_o[7:0];
      if (mem_size_o[1:0] != 2'b00) ram[mem_addr_o[12:0] + 13'd1] <= mem_data_o[15:8];
      if (mem_size_o[1:0] == 2'b10) begin
        ram[mem_addr_o[12:0] + 13'd2] <= mem_data_o[23:16];
        ram[mem_addr_o[12:0] + 13'd3] <= mem_data_o[31:24];
      end
    end
    if (mem_re_o) mem_data_i <= ram_read(mem_addr_o[12:0], mem_size_o);
  end

  int checks;
  int failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] data;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd,
                              input logic exc, input logic [3:0] cause,
                              input logic [31:0] data, input int lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.exc = exc; v.cause = cause; v.data = data; v.lat = lat;
    return v;
  endfunction

  // Drive one request (called #1 after a posedge, DUT idle), wait for the
  // response with resp_ready_i high, and check everything about it.
  task automatic run_txn(input vec_t t, input string tag);
    int          n;
    int          we_cnt, re_cnt, we_at, re_at;
    bit          got;
    logic [31:0] d, tv;
    logic        e, il;
    logic [3:0]  c;
    logic [4:0]  r;
    d = '0; tv = '0; e = 1'b0; il = 1'b0; c = '0; r = '0;
    we_cnt = 0; re_cnt = 0; we_at = 0; re_at = 0; got = 1'b0;

    req_valid_i  = 1'b1;
    req_we_i     = t.we;
    req_funct3_i = t.f3;
    req_addr_i   = t.addr;
    req_wdata_i  = t.wdata;
    req_rd_i     = t.rd;
    resp_ready_i = 1'b1;
    ref_we = t.we; ref_f3 = t.f3; ref_addr = t.addr;

    @(negedge clk);
    check({tag, "/ready_idle"}, 32'(req_ready_o), 32'd1);
    check({tag, "/ref_cause"}, 32'(ref_cause), 32'(t.cause));
    @(posedge clk); #1;
    req_valid_i = 1'b0;

    n = 1;
    while (!got && n < 20) begin
      @(negedge clk);
      if (mem_we_o) begin we_cnt++; we_at = n; end
      if (mem_re_o) begin re_cnt++; re_at = n; end
      if (n == 1 && t.lat > 1) check({tag, "/ready_busy"}, 32'(req_ready_o), 32'd0);
      if (resp_valid_o) begin
        got = 1'b1;
        d = resp_data_o; e = exc_o; c = exc_cause_o; tv = exc_tval_o;
        il = resp_is_load_o; r = resp_rd_o;
      end
      @(posedge clk); #1;
      if (!got) n++;
    end

    check({tag, "/resp_seen"}, 32'(got), 32'd1);
    check({tag, "/latency"}, 32'(n), 32'(t.lat));
    check({tag, "/exc"}, 32'(e), 32'(t.exc));
    check({tag, "/cause"}, 32'(c), 32'(t.cause));
    if (t.exc) begin
      check({tag, "/tval"}, tv, t.addr);
    end else if (!t.we) begin
      check({tag, "/data"}, d, t.data);
      check({tag, "/rd"}, 32'(r), 32'(t.rd));
    end
    check({tag, "/is_load"}, 32'(il), 32'(!t.we && !t.exc));
    check({tag, "/we_count"}, 32'(we_cnt), 32'(t.we && !t.exc));
    check({tag, "/re_count"}, 32'(re_cnt), 32'(!t.we && !t.exc));
    if (we_cnt == 1) check({tag, "/we_cycle"}, 32'(we_at), 32'd1);
    if (re_cnt == 1) check({tag, "/re_cycle"}, 32'(re_at), 32'd1);
    check({tag, "/ready_after"}, 32'(req_ready_o), 32'd1);
  endtask

  // Check that every output is at its reset value.
  task automatic check_reset_outputs(input string tag);
    check({tag, "/req_ready"}, 32'(req_ready_o), 32'd1);
    check({tag, "/resp_valid"}, 32'(resp_valid_o), 32'd0);
    check({tag, "/resp_is_load"}, 32'(resp_is_load_o), 32'd0);
    check({tag, "/resp_data"}, resp_data_o, 32'd0);
    check({tag, "/resp_rd"}, 32'(resp_rd_o), 32'd0);
    check({tag, "/exc"}, 32'(exc_o), 32'd0);
    check({tag, "/exc_cause"}, 32'(exc_cause_o), 32'd0);
    check({tag, "/exc_tval"}, exc_tval_o, 32'd0);
    check({tag, "/mem_addr"}, mem_addr_o, 32'd0);
    check({tag, "/mem_data"}, mem_data_o, 32'd0);
    check({tag, "/mem_we"}, 32'(mem_we_o), 32'd0);
    check({tag, "/mem_re"}, 32'(mem_re_o), 32'd0);
    check({tag, "/mem_size"}, 32'(mem_size_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   acc;

    checks = 0; failures = 0;
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0; req_addr_i = '0;
    req_wdata_i = '0; req_rd_i = '0; flush_i = 1'b0; resp_ready_i = 1'b1;
    ref_we = 1'b0; ref_f3 = '0; ref_addr = '0;

    //            we    f3      addr           wdata          rd     exc   cause            data           lat
    vecs.push_back(mk(1'b1, F3_SW,  32'h0000_0010, 32'hDEAD_BEEF, 5'd0,  1'b0, EXC_NONE,        32'h0,         2));
    vecs.push_back(mk(1'b0, F3_LW,  32'h0000_0010, 32'h0,         5'd5,  1'b0, EXC_NONE,        32'hDEAD_BEEF, 3));
    vecs.push_back(mk(1'b1, F3_SB,  32'h0000_0023, 32'h1234_5680, 5'd0,  1'b0, EXC_NONE,        32'h0,         2));
    vecs.push_back(mk(1'b0, F3_LB,  32'h0000_0023, 32'h0,         5'd6,  1'b0, EXC_NONE,        32'hFFFF_FF80, 3));
    vecs.push_back(mk(1'b0, F3_LBU, 32'h0000_0023, 32'h0,         5'd7,  1'b0, EXC_NONE,        32'h0000_0080, 3));
    vecs.push_back(mk(1'b1, F3_SH,  32'h0000_0042, 32'hAAAA_BEEF, 5'd0,  1'b0, EXC_NONE,        32'h0,         2));
    vecs.push_back(mk(1'b0, F3_LHU, 32'h0000_0042, 32'h0,         5'd8,  1'b0, EXC_NONE,        32'h0000_BEEF, 3));
    vecs.push_back(mk(1'b0, F3_LH,  32'h0000_0042, 32'h0,         5'd31, 1'b0, EXC_NONE,        32'hFFFF_BEEF, 3));
    vecs.push_back(mk(1'b0, F3_LH,  32'h0000_0021, 32'h0,         5'd1,  1'b1, EXC_LD_MISALIGN, 32'h0,         1));
    vecs.push_back(mk(1'b1, F3_SW,  32'h0000_0022, 32'h0,         5'd0,  1'b1, EXC_ST_MISALIGN, 32'h0,         1));
    vecs.push_back(mk(1'b0, F3_LW,  32'h0000_2000, 32'h0,         5'd2,  1'b1, EXC_LD_FAULT,    32'h0,         1));
    vecs.push_back(mk(1'b1, 3'd3,   32'h0000_0040, 32'h0,         5'd0,  1'b1, EXC_ST_FAULT,    32'h0,         1));
    vecs.push_back(mk(1'b1, 3'd3,   32'h0000_0041, 32'h0,         5'd0,  1'b1, EXC_ST_FAULT,    32'h0,         1));
    vecs.push_back(mk(1'b0, 3'd6,   32'h0000_0001, 32'h0,         5'd3,  1'b1, EXC_LD_FAULT,    32'h0,         1));
    vecs.push_back(mk(1'b0, F3_LW,  32'h0000_2002, 32'h0,         5'd4,  1'b1, EXC_LD_MISALIGN, 32'h0,         1));
    vecs.push_back(mk(1'b0, F3_LW,  32'hFFFF_FFFC, 32'h0,         5'd4,  1'b1, EXC_LD_FAULT,    32'h0,         1));
    vecs.push_back(mk(1'b1, F3_SW,  32'h0000_1FFC, 32'hCAFE_F00D, 5'd0,  1'b0, EXC_NONE,        32'h0,         2));
    vecs.push_back(mk(1'b0, F3_LW,  32'h0000_1FFC, 32'h0,         5'd9,  1'b0, EXC_NONE,        32'hCAFE_F00D, 3));
    vecs.push_back(mk(1'b0, F3_LHU, 32'h0000_1FFF, 32'h0,         5'd9,  1'b1, EXC_LD_MISALIGN, 32'h0,         1));
    vecs.push_back(mk(1'b1, F3_SB,  32'h0000_2000, 32'h0,         5'd0,  1'b1, EXC_ST_FAULT,    32'h0,         1));

    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Response stall: resp_ready_i low for 5 cycles in RESP.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = F3_LW;
    req_addr_i = 32'h0000_0010; req_rd_i = 5'd12; resp_ready_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    acc = 0;
    for (int k = 0; k < 10 && acc == 0; k++) begin
      @(negedge clk);
      if (resp_valid_o) acc = 1;
      else begin @(posedge clk); #1; end
    end
    check("stall/resp_seen", 32'(acc), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("stall%0d/valid", k), 32'(resp_valid_o), 32'd1);
      check($sformatf("stall%0d/data", k), resp_data_o, 32'hDEAD_BEEF);
      check($sformatf("stall%0d/rd", k), 32'(resp_rd_o), 32'd12);
      check($sformatf("stall%0d/req_ready", k), 32'(req_ready_o), 32'd0);
    end
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    check("stall/ready_after", 32'(req_ready_o), 32'd1);

    // Flush during CAPTURE of a load: no response, back to IDLE.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = F3_LW;
    req_addr_i = 32'h0000_0010; req_rd_i = 5'd13;
    @(posedge clk); #1;                 // cycle 1: ISSUE
    req_valid_i = 1'b0;
    @(posedge clk); #1;                 // cycle 2: CAPTURE
    flush_i = 1'b1;
    acc = 0;
    @(negedge clk);
    if (resp_valid_o) acc++;
    @(posedge clk); #1;                 // cycle 3: RESP, dropped
    flush_i = 1'b0;
    @(negedge clk);
    if (resp_valid_o) acc++;
    check("flush_cap/ready_c3", 32'(req_ready_o), 32'd0);
    @(posedge clk); #1;                 // cycle 4: IDLE
    @(negedge clk);
    if (resp_valid_o) acc++;
    check("flush_cap/resp_count", 32'(acc), 32'd0);
    check("flush_cap/idle", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;

    // Flush during ISSUE of a store: store still commits, response dropped.
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = F3_SW;
    req_addr_i = 32'h0000_0030; req_wdata_i = 32'h1111_2222;
    @(posedge clk); #1;                 // cycle 1: ISSUE
    req_valid_i = 1'b0;
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_st/we_strobe", 32'(mem_we_o), 32'd1);
    @(posedge clk); #1;                 // cycle 2: RESP, dropped
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_st/no_resp", 32'(resp_valid_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_st/idle", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    run_txn(mk(1'b0, F3_LW, 32'h0000_0030, 32'h0, 5'd14, 1'b0, EXC_NONE, 32'h1111_2222, 3), "flush_st_readback");

    // Flush in IDLE has no effect.
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_idle/ready", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    flush_i = 1'b0;

    // Reset during ISSUE of a store.
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = F3_SW;
    req_addr_i = 32'h0000_0050; req_wdata_i = 32'h0000_0055; req_rd_i = 5'd3;
    @(posedge clk); #1;                 // cycle 1: ISSUE
    req_valid_i = 1'b0;
    @(negedge clk);
    check("rst_issue/we_before", 32'(mem_we_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_issue/we_async_drop", 32'(mem_we_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_issue");

    // Unit still works after the mid-transaction reset.
    run_txn(mk(1'b0, F3_LW, 32'h0000_0010, 32'h0, 5'd15, 1'b0, EXC_NONE, 32'hDEAD_BEEF, 3), "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: initiator side of the data-RAM port. Accepts one load or store per transaction from the MEM pipeline stage and checks alignment, range and width legality. It drives the RAM's single-cycle-strobe, one-cycle-read-latency interface and returns load data or store completion to writeback over a valid/ready handshake. One transaction is in flight at a time, and the pipeline stalls on `req_ready_o`.

## Interface
- `MEM_BASE`, 32'h0000_0000, byte address of RAM word 0
- `MEM_WORDS`, 2048, RAM depth in 32-bit words; in-range iff MEM_BASE <= addr < MEM_BASE+4*MEM_WORDS
- `clk`  in  1  single clock, all state on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid_i`  in  1  request present
- `req_ready_o`  out  1  request accepted this cycle when both high
- `req_we_i`  in  1  1 = store, 0 = load
- `req_funct3_i`  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- `req_addr_i`  in  32  effective byte address
- `req_wdata_i`  in  32  store data, unshifted (rs2)
- `req_rd_i`  in  5  load destination register
- `flush_i`  in  1  discard the pending response
- `resp_valid_o`  out  1  response/exception available
- `resp_ready_i`  in  1  writeback consumes response
- `resp_is_load_o`  out  1  response carries load data
- `resp_data_o`  out  32  load data as returned by RAM (already extended)
- `resp_rd_o`  out  5  destination register
- `exc_o`  out  1  response is an exception, no memory effect
- `exc_cause_o`  out  4  4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault
- `exc_tval_o`  out  32  faulting address
- `mem_addr_o`  out  32  RAM byte address
- `mem_data_o`  out  32  RAM write data
- `mem_we_o`  out  1  RAM write strobe
- `mem_re_o`  out  1  RAM read strobe
- `mem_size_o`  out  3  RAM size code = funct3
- `mem_data_i`  in  32  RAM read data, valid the cycle after `mem_re_o`

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - `req_ready_o` = 1.
  - On accept, register all request fields and evaluate the check.
  - Check fails: go to RESP with the exception fields set.
  - Check passes: go to ISSUE.
- Check priority, first match wins:
  - Illegal funct3 gives a fault (5 or 7). Loads: 3, 6, 7 are illegal. Stores: 3 or higher is illegal.
  - Misalignment gives a misaligned cause (4 or 6). Halfword requires addr[0] = 0; word requires addr[1:0] = 0.
  - Out of range gives a fault (5 or 7).
- ISSUE, exactly one cycle:
  - `mem_re_o` = !we, or `mem_we_o` = we. Never both.
  - Store moves to RESP; load moves to CAPTURE.
- CAPTURE: register `mem_data_i` into `resp_data_o`, then go to RESP.
- RESP:
  - `resp_valid_o` = 1, with all `resp_*` and `exc_*` fields stable.
  - On `resp_ready_i` = 1, return to IDLE.
- `mem_addr_o`, `mem_data_o` and `mem_size_o` are driven from registered request fields. They hold their value outside ISSUE. Strobes are 0 outside ISSUE.
- Flush:
  - `flush_i` in ISSUE or CAPTURE: the memory access still completes (a store is committed), but a drop flag is set.
  - RESP with the drop flag set, or with `flush_i` asserted: `resp_valid_o` = 0 and return to IDLE next cycle.
  - `flush_i` in IDLE: no effect.
- Address range arithmetic uses 33-bit compares, so no wrap at 32'hFFFF_FFFC.

## Timing
- Reset value of every output is 0, except `req_ready_o` = 1 (IDLE). Reset mid-transaction drops strobes immediately and discards the transaction.
- Acceptance cycle counts as cycle 0:
  - Load: ISSUE in cycle 1, CAPTURE in cycle 2, `resp_valid_o` from cycle 3.
  - Store: write strobe in cycle 1, `resp_valid_o` from cycle 2.
  - Exception: `resp_valid_o` from cycle 1, with no strobe ever.
- `req_ready_o` is 0 from cycle 1 until the cycle after the RESP handshake. Back-to-back throughput is therefore one load per 4 cycles and one store per 3 cycles.
- No combinational path from `resp_ready_i` or `req_valid_i` to any output.

## Structure
- Package `lsu_pkg`:
  - state enum
  - funct3 constants (`F3_LB` … `F3_SW`)
  - cause codes `EXC_LD_MISALIGN`=4, `EXC_LD_FAULT`=5, `EXC_ST_MISALIGN`=6, `EXC_ST_FAULT`=7
- Sub-module `lsu_check`: purely combinational legality/alignment/range checker with inputs we, funct3, addr and outputs ok, cause. It is reused by the bench as the reference model.

## Test plan
- LW at 0x10 after SW 0xDEADBEEF to 0x10 → `mem_we_o` pulse in cycle 1; load `resp_data_o` = 0xDEADBEEF, `resp_valid_o` in cycle 3.
- SB 0x80 at 0x23, then LB and LBU at 0x23 → 0xFFFF_FF80 and 0x0000_0080.
- LH at 0x21 → exc_cause 4, tval 0x21, response in cycle 1, `mem_re_o` never asserted. SW at 0x22 → cause 6.
- LW at MEM_BASE+4*MEM_WORDS → cause 5. Store with funct3 = 3 → cause 7. Neither produces a memory strobe.
- `resp_ready_i` held low 5 cycles in RESP → outputs stable and `req_ready_o` = 0 throughout. Then `flush_i` during CAPTURE of the next load → no response and IDLE reached.
- `rst_n` asserted during ISSUE of a store → `mem_we_o` drops asynchronously, and after release `req_ready_o` = 1 and all other outputs are 0.
